// File: rtl/decode_lock_ctrl.sv
// Link bring-up controller for a group of 64B/67B RX decoders: sequences decoder
// reset/passthrough, debounces lane lock, retries stuck lanes and reports link state.
module decode_lock_ctrl #(
  parameter int NUM_LANES    = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int DEBOUNCE     = 8,
  parameter int MAX_RETRIES  = 7
) (
  input  logic                 USER_CLK,
  input  logic                 SYSTEM_RESET,
  input  logic                 ENABLE,
  input  logic                 PASSTHROUGH_REQ,
  input  logic [NUM_LANES-1:0] LANE_LOCKED,
  output logic [NUM_LANES-1:0] DEC_RESET,
  output logic                 DEC_PASSTHROUGH,
  output logic [NUM_LANES-1:0] LANE_UP,
  output logic                 LINK_UP,
  output logic [7:0]           RETRY_CNT,
  output logic                 LINK_FAIL
);

  // The timer also paces the RESET hold, so it must cover both intervals.
  localparam int TMR_W_TO  = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int TMR_W_RST = (RST_CYCLES > 2) ? $clog2(RST_CYCLES) : 1;
  localparam int TMR_W     = (TMR_W_TO > TMR_W_RST) ? TMR_W_TO : TMR_W_RST;
  localparam int DEB_W     = $clog2(DEBOUNCE + 1);

  localparam logic [TMR_W-1:0] TMR_TIMEOUT = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_RST_END = TMR_W'(RST_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_END     = DEB_W'(DEBOUNCE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_UP,
    ST_PASS,
    ST_FAIL
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_LANES-1:0] mask_reg, mask_next;
  logic [TMR_W-1:0]     timer_reg, timer_next;
  logic [DEB_W-1:0]     deb_reg, deb_next;
  logic [7:0]           retry_reg, retry_next;
  logic [7:0]           retry_inc;
  logic                 all_locked;

  logic [NUM_LANES-1:0] dec_reset_reg, dec_reset_next;
  logic [NUM_LANES-1:0] lane_up_reg, lane_up_next;
  logic                 dec_pass_reg, link_up_reg, link_fail_reg;
  logic                 lane_active;

  assign all_locked = &LANE_LOCKED;
  assign retry_inc  = (retry_reg == 8'hFF) ? 8'hFF : retry_reg + 8'd1;

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    retry_next = retry_reg;
    case (state_reg)
      ST_IDLE: begin
        if (PASSTHROUGH_REQ) begin
          state_next = ST_PASS;
        end else if (ENABLE) begin
          state_next = ST_RESET;
          mask_next  = '1;
        end
      end
      ST_RESET: begin
        if (timer_reg == TMR_RST_END) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock completing on the timeout cycle still counts as success.
        if (all_locked && deb_reg == DEB_END) begin
          state_next = ST_UP;
        end else if (timer_reg == TMR_TIMEOUT) begin
          retry_next = retry_inc;
          if (MAX_RETRIES != 0 && 32'(retry_inc) >= MAX_RETRIES) begin
            state_next = ST_FAIL;
          end else begin
            state_next = ST_RESET;
            mask_next  = ~LANE_LOCKED;
          end
        end
      end
      ST_UP: begin
        if (!all_locked && deb_reg == DEB_END) begin
          state_next = ST_RESET;
          mask_next  = '1;
        end
      end
      ST_PASS: begin
        if (!PASSTHROUGH_REQ) state_next = ST_IDLE;
      end
      ST_FAIL: ;
      default: state_next = ST_IDLE;
    endcase

    if (!ENABLE && state_reg != ST_IDLE && state_reg != ST_PASS) begin
      state_next = ST_IDLE;
      mask_next  = mask_reg;
      retry_next = retry_reg;
    end

    if (state_next == ST_IDLE || state_next == ST_UP) retry_next = 8'd0;
  end

  // Timer and debounce/loss counter restart on every state entry.
  always_comb begin
    timer_next = '0;
    deb_next   = '0;
    if (state_next == state_reg) begin
      if (state_reg == ST_RESET || state_reg == ST_WAIT_LOCK) timer_next = timer_reg + TMR_W'(1);
      if (state_reg == ST_WAIT_LOCK && all_locked) deb_next = deb_reg + DEB_W'(1);
      if (state_reg == ST_UP && !all_locked)       deb_next = deb_reg + DEB_W'(1);
    end
  end

  // Output registers are loaded from the next state so they track the state register.
  always_comb begin
    dec_reset_next = '0;
    case (state_next)
      ST_IDLE,
      ST_FAIL:  dec_reset_next = '1;
      ST_RESET: dec_reset_next = mask_next;
      default:  dec_reset_next = '0;
    endcase
  end

  assign lane_active = (state_next == ST_WAIT_LOCK) || (state_next == ST_UP);

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane_up
      assign lane_up_next[gi] = lane_active & LANE_LOCKED[gi];
    end
  endgenerate

  always_ff @(posedge USER_CLK) begin
    if (SYSTEM_RESET) begin
      state_reg     <= ST_IDLE;
      mask_reg      <= '1;
      timer_reg     <= '0;
      deb_reg       <= '0;
      retry_reg     <= 8'd0;
      dec_reset_reg <= '1;
      dec_pass_reg  <= 1'b0;
      lane_up_reg   <= '0;
      link_up_reg   <= 1'b0;
      link_fail_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mask_reg      <= mask_next;
      timer_reg     <= timer_next;
      deb_reg       <= deb_next;
      retry_reg     <= retry_next;
      dec_reset_reg <= dec_reset_next;
      dec_pass_reg  <= (state_next == ST_PASS);
      lane_up_reg   <= lane_up_next;
      link_up_reg   <= (state_next == ST_UP);
      link_fail_reg <= (state_next == ST_FAIL);
    end
  end

  assign DEC_RESET       = dec_reset_reg;
  assign DEC_PASSTHROUGH = dec_pass_reg;
  assign LANE_UP         = lane_up_reg;
  assign LINK_UP         = link_up_reg;
  assign RETRY_CNT       = retry_reg;
  assign LINK_FAIL       = link_fail_reg;

endmodule

// File: tb/tb_decode_lock_ctrl.sv
// Bench for decode_lock_ctrl: vector table for IDLE/PASS/reset behaviour, then
// hand-timed bring-up, dropout, retry/fail, disable and lock-at-timeout sequences.
module tb_decode_lock_ctrl;

  logic       USER_CLK = 1'b0;
  logic       SYSTEM_RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic       PASSTHROUGH_REQ = 1'b0;
  logic [3:0] LANE_LOCKED = 4'h0;
  logic [3:0] DEC_RESET;
  logic       DEC_PASSTHROUGH;
  logic [3:0] LANE_UP;
  logic       LINK_UP;
  logic [7:0] RETRY_CNT;
  logic       LINK_FAIL;

  decode_lock_ctrl #(
    .NUM_LANES(4), .RST_CYCLES(16), .LOCK_TIMEOUT(4096), .DEBOUNCE(8), .MAX_RETRIES(7)
  ) dut (
    .USER_CLK(USER_CLK),
    .SYSTEM_RESET(SYSTEM_RESET),
    .ENABLE(ENABLE),
    .PASSTHROUGH_REQ(PASSTHROUGH_REQ),
    .LANE_LOCKED(LANE_LOCKED),
    .DEC_RESET(DEC_RESET),
    .DEC_PASSTHROUGH(DEC_PASSTHROUGH),
    .LANE_UP(LANE_UP),
    .LINK_UP(LINK_UP),
    .RETRY_CNT(RETRY_CNT),
    .LINK_FAIL(LINK_FAIL)
  );

  always #5 USER_CLK = ~USER_CLK;

  typedef struct packed {
    logic [3:0] dec_reset;
    logic       pt;
    logic [3:0] lane_up;
    logic       link_up;
    logic [7:0] retry;
    logic       fail;
  } outs_t;

  typedef struct {
    logic       srst;
    logic       en;
    logic       pt;
    logic [3:0] lk;
    outs_t      x;
    string      nm;
  } vec_t;

  outs_t exp_q[$];
  string nm_q[$];
  int    checks = 0;
  int    passed = 0;

  function automatic outs_t mk(input logic [3:0] dr, input logic pt, input logic [3:0] lu,
                               input logic up, input logic [7:0] rc, input logic lf);
    return {dr, pt, lu, up, rc, lf};
  endfunction

  function automatic vec_t v(input logic s, input logic e, input logic p, input logic [3:0] lk,
                             input outs_t x, input string nm);
    vec_t r;
    r.srst = s; r.en = e; r.pt = p; r.lk = lk; r.x = x; r.nm = nm;
    return r;
  endfunction

  // One clock: drive inputs on the falling edge, compare just after the rising edge.
  task automatic step(input logic s, input logic e, input logic p, input logic [3:0] lk,
                      input bit chk, input string nm, input outs_t x);
    outs_t got, want;
    string n;
    @(negedge USER_CLK);
    SYSTEM_RESET = s; ENABLE = e; PASSTHROUGH_REQ = p; LANE_LOCKED = lk;
    if (chk) begin
      exp_q.push_back(x);
      nm_q.push_back(nm);
    end
    @(posedge USER_CLK);
    #1;
    if (chk) begin
      want = exp_q.pop_front();
      n    = nm_q.pop_front();
      got  = mk(DEC_RESET, DEC_PASSTHROUGH, LANE_UP, LINK_UP, RETRY_CNT, LINK_FAIL);
      checks++;
      if (got === want) begin
        passed++;
        $display("ok   %s: dr=%b pt=%b lu=%b up=%b rc=%0d lf=%b", n, got.dec_reset, got.pt,
                 got.lane_up, got.link_up, got.retry, got.fail);
      end else begin
        $display("FAIL %s: got dr=%b pt=%b lu=%b up=%b rc=%0d lf=%b, expected dr=%b pt=%b lu=%b up=%b rc=%0d lf=%b",
                 n, got.dec_reset, got.pt, got.lane_up, got.link_up, got.retry, got.fail,
                 want.dec_reset, want.pt, want.lane_up, want.link_up, want.retry, want.fail);
      end
    end
  endtask

  // After the RESET-entry step: 15 further RESET cycles, then the step entering WAIT_LOCK.
  task automatic reset_phase(input logic [3:0] mask, input logic [7:0] rc, input logic [3:0] lk,
                             input string nm);
    for (int i = 1; i < 16; i++) step(1'b0, 1'b1, 1'b0, lk, 1'b1, nm, mk(mask, 1'b0, 4'h0, 1'b0, rc, 1'b0));
    step(1'b0, 1'b1, 1'b0, lk, 1'b1, {nm, "_to_wait"}, mk(4'h0, 1'b0, lk, 1'b0, rc, 1'b0));
  endtask

  initial begin
    vec_t  tbl[11];
    outs_t idle_o, pass_o, rst_o, exp_o;
    logic [3:0] lk;
    bit chk;

    idle_o = mk(4'hF, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);
    pass_o = mk(4'h0, 1'b1, 4'h0, 1'b0, 8'd0, 1'b0);
    rst_o  = mk(4'hF, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0);

    tbl[0]  = v(1'b1, 1'b0, 1'b0, 4'h0, idle_o, "reset_values");
    tbl[1]  = v(1'b0, 1'b0, 1'b0, 4'h0, idle_o, "idle_hold");
    tbl[2]  = v(1'b0, 1'b1, 1'b1, 4'h0, pass_o, "pass_priority");
    tbl[3]  = v(1'b0, 1'b0, 1'b1, 4'h0, pass_o, "pass_ignores_enable");
    tbl[4]  = v(1'b0, 1'b1, 1'b1, 4'hF, pass_o, "pass_no_lane_up");
    tbl[5]  = v(1'b0, 1'b1, 1'b0, 4'h0, idle_o, "pass_release");
    tbl[6]  = v(1'b0, 1'b1, 1'b0, 4'hF, rst_o,  "idle_to_reset");
    tbl[7]  = v(1'b0, 1'b0, 1'b0, 4'hF, idle_o, "reset_disable");
    tbl[8]  = v(1'b0, 1'b1, 1'b0, 4'hF, rst_o,  "reset_again");
    tbl[9]  = v(1'b1, 1'b1, 1'b0, 4'hF, idle_o, "srst_in_reset");
    tbl[10] = v(1'b0, 1'b0, 1'b0, 4'h0, idle_o, "idle_after_srst");

    foreach (tbl[i]) step(tbl[i].srst, tbl[i].en, tbl[i].pt, tbl[i].lk, 1'b1, tbl[i].nm, tbl[i].x);

    // Bring-up: lanes lock 5 cycles after DEC_RESET falls, UP on the 8th locked cycle.
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "s1_reset_entry", rst_o);
    reset_phase(4'hF, 8'd0, 4'h0, "s1_reset");
    for (int k = 0; k <= 12; k++) begin
      lk    = (k >= 5) ? 4'hF : 4'h0;
      exp_o = (k == 12) ? mk(4'h0, 1'b0, 4'hF, 1'b1, 8'd0, 1'b0) : mk(4'h0, 1'b0, lk, 1'b0, 8'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, lk, 1'b1, (k == 12) ? "s1_link_up" : "s1_wait", exp_o);
    end

    // Dropouts in UP: 7 cycles tolerated, 8 cycles force a full re-reset.
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b1, 1'b0, 4'hE, 1'b1, "s3_drop7", mk(4'h0, 1'b0, 4'hE, 1'b1, 8'd0, 1'b0));
    step(1'b0, 1'b1, 1'b0, 4'hF, 1'b1, "s3_recover", mk(4'h0, 1'b0, 4'hF, 1'b1, 8'd0, 1'b0));
    for (int i = 0; i < 8; i++) begin
      exp_o = (i < 7) ? mk(4'h0, 1'b0, 4'hE, 1'b1, 8'd0, 1'b0) : rst_o;
      step(1'b0, 1'b1, 1'b0, 4'hE, 1'b1, (i < 7) ? "s3_drop8" : "s3_loss_reset", exp_o);
    end
    reset_phase(4'hF, 8'd0, 4'b1011, "s3_reset");

    // Lane 2 never locks: six partial re-resets of lane 2, then FAIL on the 7th timeout.
    for (int r = 1; r <= 7; r++) begin
      for (int k = 0; k < 4096; k++) begin
        chk = (k == 0 || k == 4094 || k == 4095);
        if (k < 4095)    exp_o = mk(4'h0, 1'b0, 4'b1011, 1'b0, 8'(r - 1), 1'b0);
        else if (r < 7)  exp_o = mk(4'b0100, 1'b0, 4'h0, 1'b0, 8'(r), 1'b0);
        else             exp_o = mk(4'hF, 1'b0, 4'h0, 1'b0, 8'd7, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'b1011, chk, (k == 4095) ? "s2_timeout" : "s2_wait", exp_o);
      end
      if (r < 7) reset_phase(4'b0100, 8'(r), 4'b1011, "s2_retry_reset");
    end
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 4'hF, 1'b1, "s2_fail_hold", mk(4'hF, 1'b0, 4'h0, 1'b0, 8'd7, 1'b1));

    // Disable out of FAIL and out of WAIT_LOCK with a nonzero retry count.
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "s5_fail_disable", idle_o);
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "s5_reset_entry", rst_o);
    reset_phase(4'hF, 8'd0, 4'h0, "s5_reset");
    for (int k = 0; k < 4096; k++) begin
      chk   = (k == 0 || k == 4095);
      exp_o = (k < 4095) ? mk(4'h0, 1'b0, 4'h0, 1'b0, 8'd0, 1'b0) : mk(4'hF, 1'b0, 4'h0, 1'b0, 8'd1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'h0, chk, (k == 4095) ? "s5_timeout_all" : "s5_wait", exp_o);
    end
    reset_phase(4'hF, 8'd1, 4'h0, "s5_reset2");
    for (int k = 0; k < 3; k++)
      step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "s5_wait2", mk(4'h0, 1'b0, 4'h0, 1'b0, 8'd1, 1'b0));
    step(1'b0, 1'b0, 1'b0, 4'h0, 1'b1, "s5_wait_disable", idle_o);

    // Eighth locked cycle lands on the final timeout cycle: UP must win.
    step(1'b0, 1'b1, 1'b0, 4'h0, 1'b1, "s6_reset_entry", rst_o);
    reset_phase(4'hF, 8'd0, 4'h0, "s6_reset");
    for (int k = 0; k < 4096; k++) begin
      lk    = (k >= 4088) ? 4'hF : 4'h0;
      chk   = (k == 4087 || k == 4094 || k == 4095);
      exp_o = (k < 4095) ? mk(4'h0, 1'b0, lk, 1'b0, 8'd0, 1'b0) : mk(4'h0, 1'b0, 4'hF, 1'b1, 8'd0, 1'b0);
      step(1'b0, 1'b1, 1'b0, lk, chk, (k == 4095) ? "s6_up_at_timeout" : "s6_wait", exp_o);
    end
    step(1'b0, 1'b1, 1'b0, 4'hF, 1'b1, "s6_up_hold", mk(4'h0, 1'b0, 4'hF, 1'b1, 8'd0, 1'b0));
    step(1'b1, 1'b1, 1'b0, 4'hF, 1'b1, "s6_srst_in_up", idle_o);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
